nt_subckt_bist_ctrl: RTL and testbench
======================================

# nt_subckt_bist_ctrl

Built-in self-test sequencer for a registered Nt-node benchmark subcircuit with three data inputs and a one-bit output. It drives the subcircuit inputs from an LFSR for a fixed number of vectors and aligns responses to the subcircuit pipeline latency. Responses are compacted into a MISR signature, and output 1s are counted so rare-activation behaviour is visible. It sits beside the subcircuit under test and is started and checked by the detection harness.

## Interface
- N_VEC, 1000: number of vectors applied per run (≥1).
- LATENCY, 2: subcircuit register depth, in cycles from input change to observable output (≥1).
- SEED, 16'hACE1: LFSR load value at run start; a value of 0 is replaced by 16'hACE1.
- I1470_clk  input  1  clock; all state updates on its rising edge.
- I1477_rst  input  1  reset; synchronous, active-low.
- start  input  1  begin a run; honoured only in IDLE.
- abort  input  1  terminate a run; honoured in RUN and DRAIN.
- golden_sig  input  16  expected signature; sampled on entry to DONE.
- dut_out  input  1  subcircuit output.
- dut_in  output  3  subcircuit data inputs; registered.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  signature == golden_sig; held until the next start.
- signature  output  16  MISR contents.
- vec_cnt  output  $clog2(N_VEC+1)  vectors applied this run.
- ones_cnt  output  $clog2(N_VEC+1)  captured responses equal to 1.

## Operation
- **Reset** (I1477_rst=0 at an edge): state IDLE; dut_in=0, busy=0, done=0, pass=0, signature=0, vec_cnt=0, ones_cnt=0, lfsr=SEED, capture pipe cleared. This applies from any state, including mid-run.
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN** on start=1 and abort=0. At that edge:
  - load lfsr=SEED;
  - set dut_in=SEED[2:0];
  - clear signature, vec_cnt, ones_cnt, pass.
  - If start and abort are both 1 in IDLE, abort wins and the block stays in IDLE.
- **RUN:**
  - Each edge advances the LFSR and sets dut_in=lfsr_next[2:0].
  - vec_cnt increments per vector applied.
  - Transition to DRAIN after N_VEC vectors.
  - start is ignored.
- **LFSR:** 16-bit Fibonacci, shift left. fb = q[15]^q[13]^q[12]^q[10], next = {q[14:0], fb}.
- **DRAIN:**
  - dut_in=0.
  - Stays LATENCY cycles, then goes to DONE.
- **Capture pipe:** LATENCY-deep valid shift register, fed 1 for each RUN cycle. When the tap is 1 at an edge:
  - signature ← ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0)) ^ {15'b0, dut_out};
  - ones_cnt increments when dut_out=1.
- **DONE:**
  - done=1 for one cycle.
  - pass registered from signature==golden_sig.
  - Next state IDLE.
  - signature, counts and pass hold until the next start.
- **abort=1 in RUN or DRAIN:**
  - next state IDLE; busy=0; dut_in=0;
  - no done pulse; pass=0;
  - signature and counts frozen at their values.
- **Widths:** counters saturate neither in nor out of range; the maximum value is N_VEC.

## Timing
- start is high in cycle 0 (IDLE).
- Cycle 1: RUN, busy=1, dut_in = vector 0.
- Vector k is on dut_in in cycle 1+k, for k = 0..N_VEC-1.
- The response to vector k is sampled at the end of cycle 1+k+LATENCY.
- DRAIN occupies cycles N_VEC+1 .. N_VEC+LATENCY.
- done=1 and pass become valid in cycle N_VEC+LATENCY+1.
- busy is low in that cycle; busy is high for exactly N_VEC+LATENCY cycles.
- The earliest restart is start sampled in cycle N_VEC+LATENCY+2.

## Structure
- Package nt_bist_pkg contains:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - SIG_W=16;
  - MISR_POLY=16'h1021;
  - LFSR tap constants;
  - DEFAULT_SEED=16'hACE1.
- Sub-module nt_bist_misr holds the signature register. Its ports are clock, reset, clear, enable, data bit, and signature.
- The FSM, LFSR, counters and capture pipe stay in the top module.

## Test plan
- **Reset:** hold I1477_rst=0 for 2 cycles with start=1 → all outputs 0, state IDLE, no busy.
- **Vector order:** N_VEC=4, LATENCY=2, SEED=16'h0001, dut_out tied 0 → dut_in is 1, 2, 4, 0 in cycles 1–4; busy high in cycles 1–6; done pulse in cycle 7; signature=0; ones_cnt=0; with golden_sig=0, pass=1.
- **All-ones response:** same configuration, dut_out tied 1 → ones_cnt=4, signature=16'h000F, vec_cnt=4.
- **Abort:** N_VEC=1000, abort asserted in cycle 10 → IDLE in cycle 11, busy=0, no done, pass=0, vec_cnt=10.
- **Start handling:** start pulsed during RUN → no restart, and vector order is unchanged. start and abort both high in IDLE → remains IDLE.
- **Reset mid-run:** I1477_rst=0 in the first DRAIN cycle → next cycle shows all outputs at reset values. A following start runs cleanly from SEED.

Source files
------------

// File: rtl/nt_bist_pkg.sv
// Shared types, constants and step functions for the Nt subcircuit BIST sequencer.
// The LFSR and MISR update rules live here so every user applies the same polynomial.
package nt_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  localparam int              SIG_W        = 16;
  localparam logic [SIG_W-1:0] MISR_POLY   = 16'h1021;
  // Fibonacci taps at bits 15, 13, 12 and 10
  localparam logic [15:0]     LFSR_TAPS    = 16'hB400;
  localparam logic [15:0]     DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic d);
    return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}}))
           ^ {{(SIG_W-1){1'b0}}, d};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/nt_subckt_bist_ctrl_if.sv
// Harness-facing bundle of the BIST sequencer: run control, subcircuit drive/response, results.
// Control is level-sampled on the rising clock (start/abort); done is a one-cycle strobe.
interface nt_subckt_bist_ctrl_if #(
  parameter int N_VEC = 1000
);
  import nt_bist_pkg::*;

  localparam int CW = $clog2(N_VEC + 1);

  logic              start;
  logic              abort;
  logic [SIG_W-1:0]  golden_sig;
  logic              dut_out;
  logic [2:0]        dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [SIG_W-1:0]  signature;
  logic [CW-1:0]     vec_cnt;
  logic [CW-1:0]     ones_cnt;
  bist_state_t       dbg_state;

  modport master (
    output start, abort, golden_sig, dut_out,
    input  dut_in, busy, done, pass, signature, vec_cnt, ones_cnt, dbg_state
  );

  modport slave (
    input  start, abort, golden_sig, dut_out,
    output dut_in, busy, done, pass, signature, vec_cnt, ones_cnt, dbg_state
  );

endinterface

// File: rtl/nt_bist_misr.sv
// 16-bit serial-input MISR compacting the one-bit subcircuit response stream.
// clear has priority over en so a new run always starts from a zero signature.
module nt_bist_misr
  import nt_bist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = misr_step(sig_q, data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/nt_subckt_bist_ctrl.sv
// BIST sequencer: LFSR stimulus for N_VEC vectors, LATENCY-aligned response capture into a MISR,
// ones counting, and a pass/fail verdict against the harness-supplied golden signature.
module nt_subckt_bist_ctrl
  import nt_bist_pkg::*;
#(
  parameter int          N_VEC   = 1000,
  parameter int          LATENCY = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                 I1470_clk,
  input  logic                 I1477_rst,
  nt_subckt_bist_ctrl_if.slave bus
);

  localparam int            CW         = $clog2(N_VEC + 1);
  localparam int            DW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [15:0]   SEED_EFF   = seed_fix(SEED);
  localparam logic [CW-1:0] LAST_VEC   = CW'(N_VEC - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(LATENCY - 1);

  bist_state_t        state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d, lfsr_nxt;
  logic [2:0]         dut_in_q, dut_in_d;
  logic [CW-1:0]      vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]      ones_cnt_q, ones_cnt_d;
  logic               pass_q, pass_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [SIG_W-1:0]   sig_q, sig_nxt;

  logic busy_c, done_c, load_run, in_run, stop, enter_done, capture;

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort)                   state_d = ST_IDLE;
        else if (vec_cnt_q == LAST_VEC)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)                   state_d = ST_IDLE;
        else if (drain_q == LAST_DRAIN)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs / controls
  always_comb begin
    busy_c     = 1'b0;
    done_c     = 1'b0;
    load_run   = 1'b0;
    in_run     = 1'b0;
    stop       = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: load_run = bus.start && !bus.abort;
      ST_RUN: begin
        busy_c = 1'b1;
        in_run = 1'b1;
        stop   = bus.abort;
      end
      ST_DRAIN: begin
        busy_c     = 1'b1;
        stop       = bus.abort;
        enter_done = !bus.abort && (drain_q == LAST_DRAIN);
      end
      ST_DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath next state
  always_comb begin
    lfsr_nxt   = lfsr_step(lfsr_q);
    sig_nxt    = misr_step(sig_q, bus.dut_out);
    capture    = pipe_q[LATENCY-1] && !stop;

    lfsr_d     = lfsr_q;
    dut_in_d   = dut_in_q;
    vec_cnt_d  = vec_cnt_q;
    ones_cnt_d = ones_cnt_q;
    pass_d     = pass_q;
    drain_d    = '0;

    pipe_d[0] = in_run;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (load_run) begin
      lfsr_d     = SEED_EFF;
      dut_in_d   = SEED_EFF[2:0];
      vec_cnt_d  = '0;
      ones_cnt_d = '0;
      pass_d     = 1'b0;
    end

    // The vector on dut_in this cycle counts as applied, even on an aborting edge.
    if (in_run) begin
      lfsr_d    = lfsr_nxt;
      vec_cnt_d = vec_cnt_q + CW'(1);
      dut_in_d  = (vec_cnt_q == LAST_VEC) ? 3'b000 : lfsr_nxt[2:0];
    end

    if (state_q == ST_DRAIN) drain_d = drain_q + DW'(1);

    if (capture && bus.dut_out) ones_cnt_d = ones_cnt_q + CW'(1);

    // The last response is captured on the same edge that enters DONE.
    if (enter_done) pass_d = ((capture ? sig_nxt : sig_q) == bus.golden_sig);

    if (stop) begin
      dut_in_d = '0;
      pass_d   = 1'b0;
      pipe_d   = '0;
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      lfsr_q     <= SEED_EFF;
      dut_in_q   <= '0;
      vec_cnt_q  <= '0;
      ones_cnt_q <= '0;
      pass_q     <= 1'b0;
      drain_q    <= '0;
      pipe_q     <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      dut_in_q   <= dut_in_d;
      vec_cnt_q  <= vec_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      pass_q     <= pass_d;
      drain_q    <= drain_d;
      pipe_q     <= pipe_d;
    end
  end

  nt_bist_misr u_misr (
    .clk_i   (I1470_clk),
    .rst_ni  (I1477_rst),
    .clear_i (load_run),
    .en_i    (capture),
    .data_i  (bus.dut_out),
    .sig_o   (sig_q)
  );

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.vec_cnt   = vec_cnt_q;
  assign bus.ones_cnt  = ones_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_nt_subckt_bist_ctrl.sv
// Bench for nt_subckt_bist_ctrl: a short configuration (N_VEC=4, LATENCY=2, SEED=1) for run results
// and a long one (N_VEC=1000, SEED=0 -> default seed) for abort behaviour.
module tb_nt_subckt_bist_ctrl;
  import nt_bist_pkg::*;

  localparam int NS = 4;
  localparam int NB = 1000;
  localparam int RW = 16 + 3 + 3 + 1 + 4;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;
  int   busy_cyc = 0;
  logic r1 = 1'b0;
  logic r2 = 1'b0;

  logic [RW-1:0] exp_q[$];
  logic [2:0]    vec_q[$];
  logic [2:0]    vecb_q[$];

  // ---------------------------------------------------------------- clock / DUTs
  always #5 clk = ~clk;

  nt_subckt_bist_ctrl_if #(.N_VEC(NS)) bus_s ();
  nt_subckt_bist_ctrl_if #(.N_VEC(NB)) bus_b ();

  nt_subckt_bist_ctrl #(.N_VEC(NS), .LATENCY(2), .SEED(16'h0001)) dut_s (
    .I1470_clk (clk),
    .I1477_rst (rst_s),
    .bus       (bus_s)
  );

  nt_subckt_bist_ctrl #(.N_VEC(NB), .LATENCY(2), .SEED(16'h0000)) dut_b (
    .I1470_clk (clk),
    .I1477_rst (rst_b),
    .bus       (bus_b)
  );

  // Two-register subcircuit model whose output is bit 0 of its input (mode 2).
  always @(posedge clk) begin
    r1 <= bus_s.dut_in[0];
    r2 <= r1;
  end

  assign bus_s.dut_out = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : r2;
  assign bus_b.dut_out = 1'b0;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  function automatic logic [RW-1:0] mk(input logic [15:0] sig, input int ones, input int vec,
                                       input logic pass, input int bcyc);
    return {sig, 3'(ones), 3'(vec), pass, 4'(bcyc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vecs();
    vec_q.push_back(3'd1);
    vec_q.push_back(3'd2);
    vec_q.push_back(3'd4);
    vec_q.push_back(3'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus_s.dbg_state != ST_DONE && n < 30) begin
      tick();
      n++;
    end
    if (bus_s.dbg_state != ST_DONE) fail_now("done_timeout");
    tick();
  endtask

  task automatic run_small(input int m, input logic [15:0] gold, input logic [RW-1:0] exp);
    mode = m;
    bus_s.golden_sig = gold;
    push_vecs();
    exp_q.push_back(exp);
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    wait_done();
  endtask

  // ---------------------------------------------------------------- scoreboard monitors
  always @(negedge clk) begin
    logic [RW-1:0] act;
    if (bus_s.dbg_state == ST_IDLE) busy_cyc = 0;
    else if (bus_s.busy) busy_cyc++;
    if (bus_s.dbg_state == ST_RUN) begin
      if (vec_q.size() == 0) fail_now("vec_extra");
      else check("dut_in", 64'(bus_s.dut_in), 64'(vec_q.pop_front()));
    end
    if (bus_s.done) begin
      act = {bus_s.signature, bus_s.ones_cnt, bus_s.vec_cnt, bus_s.pass, 4'(busy_cyc)};
      if (exp_q.size() == 0) fail_now("done_unexpected");
      else check("result", 64'(act), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bus_b.dbg_state == ST_RUN && vecb_q.size() > 0)
      check("dut_in_b", 64'(bus_b.dut_in), 64'(vecb_q.pop_front()));
    if (bus_b.done) fail_now("done_b_unexpected");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_s = 1'b0;
    rst_b = 1'b0;
    bus_s.start = 1'b1;
    bus_s.abort = 1'b0;
    bus_s.golden_sig = 16'h0000;
    bus_b.start = 1'b1;
    bus_b.abort = 1'b0;
    bus_b.golden_sig = 16'h0000;
    tick();
    tick();

    check("rst_outs_s", 64'({bus_s.dut_in, bus_s.busy, bus_s.done, bus_s.pass, bus_s.signature,
                            bus_s.vec_cnt, bus_s.ones_cnt}), 64'(0));
    check("rst_state_s", 64'(bus_s.dbg_state), 64'(ST_IDLE));
    check("rst_outs_b", 64'({bus_b.dut_in, bus_b.busy, bus_b.done, bus_b.pass, bus_b.signature,
                            bus_b.vec_cnt, bus_b.ones_cnt}), 64'(0));

    bus_s.start = 1'b0;
    bus_b.start = 1'b0;
    rst_s = 1'b1;
    rst_b = 1'b1;
    tick();

    // Vector order, all-zero response, golden 0.
    run_small(0, 16'h0000, mk(16'h0000, 0, 4, 1'b1, 6));
    // All-ones response: 0 -> 1 -> 3 -> 7 -> F.
    run_small(1, 16'h000F, mk(16'h000F, 4, 4, 1'b1, 6));
    repeat (3) tick();
    check("pass_hold", 64'(bus_s.pass), 64'(1));
    check("sig_hold", 64'(bus_s.signature), 64'(16'h000F));
    check("ones_hold", 64'(bus_s.ones_cnt), 64'(4));
    // Response = bit 0 of each vector: 1,0,0,0 -> signature 8.
    run_small(2, 16'h0000, mk(16'h0008, 1, 4, 1'b0, 6));

    // start together with abort in IDLE: no run, previous results kept.
    bus_s.start = 1'b1;
    bus_s.abort = 1'b1;
    tick();
    bus_s.start = 1'b0;
    bus_s.abort = 1'b0;
    check("startabort_state", 64'(bus_s.dbg_state), 64'(ST_IDLE));
    check("startabort_busy", 64'(bus_s.busy), 64'(0));
    check("startabort_sig", 64'(bus_s.signature), 64'(16'h0008));
    tick();

    // start pulsed mid-run is ignored.
    mode = 1;
    bus_s.golden_sig = 16'h0000;
    push_vecs();
    exp_q.push_back(mk(16'h000F, 4, 4, 1'b0, 6));
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    tick();
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    wait_done();

    // Reset asserted in the first DRAIN cycle.
    mode = 1;
    push_vecs();
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    repeat (4) tick();
    check("drain_entry", 64'(bus_s.dbg_state), 64'(ST_DRAIN));
    rst_s = 1'b0;
    tick();
    rst_s = 1'b1;
    check("midrst_outs", 64'({bus_s.dut_in, bus_s.busy, bus_s.done, bus_s.pass, bus_s.signature,
                             bus_s.vec_cnt, bus_s.ones_cnt}), 64'(0));
    check("midrst_state", 64'(bus_s.dbg_state), 64'(ST_IDLE));
    tick();
    run_small(1, 16'h000F, mk(16'h000F, 4, 4, 1'b1, 6));

    // Abort in cycle 10 of a long run; zero seed falls back to ACE1 -> 1,3,7,7.
    vecb_q.push_back(3'd1);
    vecb_q.push_back(3'd3);
    vecb_q.push_back(3'd7);
    vecb_q.push_back(3'd7);
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    repeat (9) tick();
    check("abort_busy_before", 64'(bus_b.busy), 64'(1));
    bus_b.abort = 1'b1;
    tick();
    bus_b.abort = 1'b0;
    check("abort_state", 64'(bus_b.dbg_state), 64'(ST_IDLE));
    check("abort_busy", 64'(bus_b.busy), 64'(0));
    check("abort_done", 64'(bus_b.done), 64'(0));
    check("abort_pass", 64'(bus_b.pass), 64'(0));
    check("abort_vec_cnt", 64'(bus_b.vec_cnt), 64'(10));
    check("abort_dut_in", 64'(bus_b.dut_in), 64'(0));
    check("abort_ones", 64'(bus_b.ones_cnt), 64'(0));
    repeat (5) tick();
    check("abort_vec_frozen", 64'(bus_b.vec_cnt), 64'(10));

    repeat (3) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("vec_q_drained", 64'(vec_q.size()), 64'(0));
    check("vecb_q_drained", 64'(vecb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
